// File: rtl/decade_step_sequencer_if.sv
// Control/status bundle for decade_step_sequencer; master drives controls, slave is the sequencer.
// The pause signal exists only when DECADE_SEQ_PAUSE_EN is defined.
interface decade_step_sequencer_if #(
  parameter int unsigned DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               loop_mode;
  logic [3:0]         last_step;
  logic [DWELL_W-1:0] dwell;
`ifdef DECADE_SEQ_PAUSE_EN
  logic               pause;
`endif
  logic [9:0]         step_q;
  logic [3:0]         step_idx;
  logic               busy;
  logic               adv;
  logic               done;
  logic               carry_out;

`ifdef DECADE_SEQ_PAUSE_EN
  modport master (
    output start, stop, loop_mode, last_step, dwell, pause,
    input  step_q, step_idx, busy, adv, done, carry_out
  );
  modport slave (
    input  start, stop, loop_mode, last_step, dwell, pause,
    output step_q, step_idx, busy, adv, done, carry_out
  );
`else
  modport master (
    output start, stop, loop_mode, last_step, dwell,
    input  step_q, step_idx, busy, adv, done, carry_out
  );
  modport slave (
    input  start, stop, loop_mode, last_step, dwell,
    output step_q, step_idx, busy, adv, done, carry_out
  );
`endif
endinterface

// File: rtl/decade_step_sequencer.sv
// Programmable one-hot decade step sequencer (4017-style) with dwell, loop and stop control.
// Define DECADE_SEQ_PAUSE_EN to add the pause input and PAUSE state.
module decade_step_sequencer #(
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned NSTEPS  = 10
) (
  input  logic                  cp,
  input  logic                  mr,
  decade_step_sequencer_if.slave bus
);
  localparam int unsigned       IDX_W    = 4;
  localparam int unsigned       HALF     = NSTEPS / 2;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NSTEPS - 1);

`ifdef DECADE_SEQ_PAUSE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2} state_e;
`else
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;
`endif

  state_e             state_q, state_d;
  logic [NSTEPS-1:0]  onehot_q, onehot_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   last_clamped;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               loop_q, loop_d;
  logic               busy_q, busy_d;
  logic               adv_q, adv_d;
  logic               done_q, done_d;
  logic               carry_q, carry_d;

  // Next-state and output decode; shadow config is only written on a run start.
  always_comb begin
    state_d      = state_q;
    onehot_d     = onehot_q;
    idx_d        = idx_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    dwell_d      = dwell_q;
    loop_d       = loop_q;
    busy_d       = busy_q;
    adv_d        = 1'b0;
    done_d       = 1'b0;
    last_clamped = (bus.last_step > LAST_IDX) ? LAST_IDX : bus.last_step;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d  = S_RUN;
          loop_d   = bus.loop_mode;
          last_d   = last_clamped;
          dwell_d  = bus.dwell;
          cnt_d    = bus.dwell;
          onehot_d = NSTEPS'(1);
          idx_d    = '0;
          busy_d   = 1'b1;
        end
      end
      default: begin
        if (bus.stop) begin
          state_d  = S_IDLE;
          onehot_d = '0;
          idx_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b0;
        end
`ifdef DECADE_SEQ_PAUSE_EN
        else if (bus.pause) begin
          state_d = S_PAUSE;
        end
`endif
        else begin
          // A resume edge out of PAUSE counts as a normal run cycle.
          state_d = S_RUN;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else if (idx_q != last_q) begin
            onehot_d = {onehot_q[NSTEPS-2:0], onehot_q[NSTEPS-1]};
            idx_d    = idx_q + IDX_W'(1);
            cnt_d    = dwell_q;
            adv_d    = 1'b1;
          end else if (loop_q) begin
            onehot_d = NSTEPS'(1);
            idx_d    = '0;
            cnt_d    = dwell_q;
            adv_d    = 1'b1;
          end else begin
            state_d  = S_IDLE;
            onehot_d = '0;
            idx_d    = '0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
    endcase

    carry_d = ~|onehot_d[NSTEPS-1:HALF];
  end

  // State and output registers.
  always_ff @(posedge cp or posedge mr) begin
    if (mr) begin
      state_q  <= S_IDLE;
      onehot_q <= '0;
      idx_q    <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      dwell_q  <= '0;
      loop_q   <= 1'b0;
      busy_q   <= 1'b0;
      adv_q    <= 1'b0;
      done_q   <= 1'b0;
      carry_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      loop_q   <= loop_d;
      busy_q   <= busy_d;
      adv_q    <= adv_d;
      done_q   <= done_d;
      carry_q  <= carry_d;
    end
  end

  assign bus.step_q    = onehot_q;
  assign bus.step_idx  = idx_q;
  assign bus.busy      = busy_q;
  assign bus.adv       = adv_q;
  assign bus.done      = done_q;
  assign bus.carry_out = carry_q;
endmodule

// File: tb/tb_decade_step_sequencer.sv
// Self-checking bench for decade_step_sequencer: run table plus hand sequences for stop, reset and pause.
module tb_decade_step_sequencer;
  logic cp = 1'b0;
  logic mr;
  always #5 cp = ~cp;

  decade_step_sequencer_if #(.DWELL_W(8)) bus();
  decade_step_sequencer #(.DWELL_W(8), .NSTEPS(10)) dut (.cp(cp), .mr(mr), .bus(bus));

  typedef struct packed {
    logic [9:0] sq;
    logic [3:0] idx;
    logic       busy;
    logic       adv;
    logic       done;
    logic       carry;
  } obs_t;

  typedef struct {
    logic       lp;
    logic [3:0] last;
    logic [7:0] dwell;
    int         ncyc;
    logic       noise;
  } vec_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[7];

  // Expected outputs after p progressing cycles of a run started with (lp, last, dwell+1=d).
  function automatic obs_t exp_at(logic lp, int last, int d, int p);
    obs_t o;
    int   l, len, s;
    o   = '0;
    l   = (last > 9) ? 9 : last;
    len = (l + 1) * d;
    if (!lp && p >= len) begin
      o.carry = 1'b1;
      o.done  = (p == len);
      return o;
    end
    s       = (p / d) % (l + 1);
    o.sq    = 10'(1) << s;
    o.idx   = 4'(s);
    o.busy  = 1'b1;
    o.adv   = (p > 0) && (p % d == 0);
    o.carry = (s < 5);
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o       = '0;
    o.carry = 1'b1;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.sq    = bus.step_q;
    o.idx   = bus.step_idx;
    o.busy  = bus.busy;
    o.adv   = bus.adv;
    o.done  = bus.done;
    o.carry = bus.carry_out;
    return o;
  endfunction

  task automatic check(input string name, input int t);
    obs_t e, a;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s t=%0d: scoreboard empty", name, t);
      return;
    end
    e = exp_q.pop_front();
    a = observe();
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s t=%0d: got sq=%b idx=%0d busy=%b adv=%b done=%b carry=%b, want sq=%b idx=%0d busy=%b adv=%b done=%b carry=%b",
               name, t, a.sq, a.idx, a.busy, a.adv, a.done, a.carry,
               e.sq, e.idx, e.busy, e.adv, e.done, e.carry);
    end
  endtask

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.loop_mode = 1'b0;
    bus.last_step = 4'd0;
    bus.dwell     = 8'd0;
  endtask

  task automatic begin_run(input logic lp, input logic [3:0] last, input logic [7:0] dwell);
    bus.loop_mode = lp;
    bus.last_step = last;
    bus.dwell     = dwell;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, l, d;
    vecs[0] = '{1'b0, 4'd2,  8'd1, 8,  1'b0};
    vecs[1] = '{1'b1, 4'd9,  8'd0, 22, 1'b0};
    vecs[2] = '{1'b0, 4'd13, 8'd0, 12, 1'b1};
    vecs[3] = '{1'b0, 4'd3,  8'd4, 22, 1'b1};
    vecs[4] = '{1'b1, 4'd0,  8'd2, 10, 1'b1};
    vecs[5] = '{1'b0, 4'd0,  8'd0, 3,  1'b0};
    vecs[6] = '{1'b1, 4'd4,  8'd1, 14, 1'b1};

    quiet_inputs();
`ifdef DECADE_SEQ_PAUSE_EN
    bus.pause = 1'b0;
`endif
    mr = 1'b1;
    #12;
    exp_q.push_back(idle_obs());
    check("reset", 0);
    @(negedge cp);
    mr = 1'b0;
    tick();
    exp_q.push_back(idle_obs());
    check("idle_after_reset", 0);

    // start together with stop must leave the sequencer idle
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    exp_q.push_back(idle_obs());
    check("start_stop_same", 0);
    quiet_inputs();
    tick();
    exp_q.push_back(idle_obs());
    check("start_stop_after", 1);

    foreach (vecs[i]) begin
      l   = (vecs[i].last > 9) ? 9 : int'(vecs[i].last);
      d   = int'(vecs[i].dwell) + 1;
      len = (l + 1) * d;
      for (int t = 0; t < vecs[i].ncyc; t++)
        exp_q.push_back(exp_at(vecs[i].lp, int'(vecs[i].last), d, t));
      begin_run(vecs[i].lp, vecs[i].last, vecs[i].dwell);
      for (int t = 0; t < vecs[i].ncyc; t++) begin
        check($sformatf("vec%0d", i), t);
        if (vecs[i].noise && (vecs[i].lp || t < len)) begin
          bus.start     = 1'($urandom);
          bus.loop_mode = 1'($urandom);
          bus.last_step = 4'($urandom);
          bus.dwell     = 8'($urandom);
        end else begin
          quiet_inputs();
        end
        tick();
      end
      quiet_inputs();
      if (vecs[i].lp) begin
        exp_q.push_back(exp_at(vecs[i].lp, int'(vecs[i].last), d, vecs[i].ncyc));
        check($sformatf("vec%0d_tail", i), vecs[i].ncyc);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        exp_q.push_back(idle_obs());
        check($sformatf("vec%0d_stop", i), 0);
      end else begin
        exp_q.push_back(idle_obs());
        check($sformatf("vec%0d_idle", i), vecs[i].ncyc);
      end
      tick();
    end

    // stop during step 4 of a one-shot run: idle next cycle, no done
    for (int t = 0; t <= 12; t++) exp_q.push_back(exp_at(1'b0, 9, 3, t));
    begin_run(1'b0, 4'd9, 8'd2);
    for (int t = 0; t <= 12; t++) begin
      check("stop_run", t);
      if (t < 12) tick();
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    exp_q.push_back(idle_obs());
    check("stop_idle", 0);
    tick();
    exp_q.push_back(idle_obs());
    check("stop_idle2", 1);

    // asynchronous reset while in step 3
    for (int t = 0; t <= 6; t++) exp_q.push_back(exp_at(1'b0, 9, 2, t));
    begin_run(1'b0, 4'd9, 8'd1);
    for (int t = 0; t <= 6; t++) begin
      check("mr_run", t);
      if (t < 6) tick();
    end
    #2 mr = 1'b1;
    #1;
    exp_q.push_back(idle_obs());
    check("mr_async", 0);
    tick();
    exp_q.push_back(idle_obs());
    check("mr_held", 1);
    @(negedge cp);
    mr = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      exp_q.push_back(idle_obs());
      check("mr_released", t);
    end

`ifdef DECADE_SEQ_PAUSE_EN
    // pause for 5 cycles during step 0 of last_step=1, dwell=3
    begin
      int   p;
      logic frozen;
      obs_t e;
      p      = 0;
      frozen = 1'b0;
      begin_run(1'b0, 4'd1, 8'd3);
      for (int f = 0; f < 16; f++) begin
        e = exp_at(1'b0, 1, 4, p);
        if (frozen) e.adv = 1'b0;
        exp_q.push_back(e);
        check("pause", f);
        bus.pause = (f >= 1 && f <= 5);
        bus.start = (f == 3);
        frozen    = bus.pause;
        if (!bus.pause) p++;
        tick();
      end
      bus.pause = 1'b0;
      bus.start = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decade_step_sequencer.md
Name: decade_step_sequencer

Overview:
- Programmable step sequencer built around a 10-output one-hot decade counter (4017-style).
- Advances a one-hot step through steps 0..N. Each step is held for a programmable dwell.
- Supports one-shot and looping runs, with start/stop control and done/advance strobes.
- Sequences downstream enables (mux selects, scan phases) in the parts-bin logic library.

Parameters:
- DWELL_W, 8, width of dwell count. Each step lasts dwell+1 cycles.
- NSTEPS, 10, number of one-hot step outputs. Fixed at 10 for decade compatibility; other values unsupported.

Ports:
- cp  input  1  clock, rising edge
- mr  input  1  master reset, asynchronous, active-high
- start  input  1  pulse: begin a run when idle
- stop  input  1  pulse/level: abort the run
- loop_mode  input  1  1 = wrap to step 0 after last step; 0 = one-shot
- last_step  input  4  final step index, 0..9; values >9 clamp to 9
- dwell  input  DWELL_W  cycles-per-step minus one
- step_q  output  10  one-hot active step; all zero when idle
- step_idx  output  4  binary index of the active step; 0 when idle
- busy  output  1  high while running
- adv  output  1  one-cycle strobe when the step changes (not on entry to step 0 from idle)
- done  output  1  one-cycle strobe at one-shot completion
- carry_out  output  1  ~|step_q[9:5]: high for steps 0..4 and when idle

Behaviour:
- Reset (mr high, async):
  - state=IDLE, step_q=0, step_idx=0, busy=0, adv=0, done=0, carry_out=1.
  - Dwell counter and latched config cleared. Reset mid-run aborts immediately; no done.
- States: IDLE, RUN (plus PAUSE when the optional feature is enabled).
- IDLE:
  - On a start=1 edge with stop=0: latch loop_mode, clamped last_step and dwell into shadow registers.
  - Next cycle: step_q=10'b1, step_idx=0, busy=1, dwell_cnt=dwell, state=RUN.
  - start and stop in the same cycle: stop wins, stay IDLE.
- RUN, each cycle:
  - stop=1: next cycle state=IDLE, step_q=0, busy=0, done=0, adv=0.
  - Else if dwell_cnt!=0: dwell_cnt decrements by 1.
  - Else if step_idx != last_step (latched): rotate step_q left by 1, step_idx+1, reload dwell_cnt, adv=1 for one cycle.
  - Else if loop: step_q=10'b1, step_idx=0, reload dwell_cnt, adv=1.
  - Else (one-shot end): state=IDLE, step_q=0, busy=0, done=1 for one cycle.
- Timing:
  - Start-to-step-0: 1 cycle.
  - One-shot run length: (last_step+1)*(dwell+1) cycles of busy.
  - dwell=0: a new step every cycle.
- start while busy is ignored. Input changes while busy have no effect until the next start.
- last_step=0 with loop=1: step 0 is held permanently and adv pulses every dwell+1 cycles.
- step_q is always one-hot or zero; no illegal pattern is reachable.
- Registered outputs only. carry_out is decoded from the step_q register.

Optional Feature:
- Macro: DECADE_SEQ_PAUSE_EN.
- Defined:
  - Adds port pause (input, 1): hold while high.
  - In RUN with pause=1 and stop=0: enter PAUSE. dwell_cnt and step_q are frozen, busy stays 1, adv=0.
  - pause=0 returns to RUN and resumes the count where it stopped.
  - stop in PAUSE goes to IDLE as in RUN. start in PAUSE is ignored.
  - The total run is extended by exactly the number of paused cycles.
- Undefined: no pause port and no PAUSE state. Behaviour is otherwise identical.

Test Plan:
- Reset: assert mr mid-run at step 3 → same cycle: step_q=0, busy=0, carry_out=1; no done after release.
- One-shot: last_step=2, dwell=1, loop=0, start → step_q 001,001,010,010,100,100 (6 busy cycles), then done=1 for one cycle, step_q=0; adv pulses twice.
- Loop/carry: last_step=9, dwell=0, loop=1 → step_q walks bit0..bit9 then bit0. carry_out is 1 for bits 0-4 and 0 for bits 5-9. adv=1 on every cycle after the first.
- Stop/priority: start and stop together → stays IDLE. Stop at step 4 of a run → IDLE the next cycle, done=0.
- Clamp/ignore: last_step=13 → run ends after step 9. Changing dwell or start mid-run leaves timing unchanged.
- With DECADE_SEQ_PAUSE_EN: last_step=1, dwell=3, pause for 5 cycles during step 0 → busy lasts 8+5=13 cycles and step_q is frozen during the pause.
